// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg
//   Shared definitions for the sram_resp slice: RV32I funct3 memop codes,
//   the responder state enum and small decode helpers for memop legality
//   and alignment.
package sram_resp_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Unsigned widths only make sense for loads; 011/110/111 are reserved.
  function automatic logic memop_legal(input logic [2:0] memop, input logic wen);
    case (memop)
      MEMOP_B, MEMOP_H, MEMOP_W: return 1'b1;
      MEMOP_BU, MEMOP_HU:        return !wen;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic memop_misaligned(input logic [2:0] memop, input logic [1:0] lane);
    case (memop)
      MEMOP_H, MEMOP_HU: return lane[0];
      MEMOP_W:           return lane != 2'b00;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational lane steering for a 32-bit word memory.
//   Ports:
//     memop   [2:0]  RV32I funct3 width/sign code
//     lane    [1:0]  byte address bits [1:0]
//     wdata   [31:0] LSB-justified store data
//     rword   [31:0] word currently held in the array
//     st_be   [3:0]  byte enables for a store
//     st_data [31:0] store data replicated onto every lane
//     ld_data [31:0] addressed lane shifted to bit 0 and extended
module mem_lane_align
  import sram_resp_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_be    = '0;
    st_data  = '0;
    ld_data  = '0;
    byte_sel = rword[8*lane +: 8];
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
    case (memop)
      MEMOP_B, MEMOP_BU: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{wdata[7:0]}};
      end
      MEMOP_H, MEMOP_HU: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      MEMOP_W: begin
        st_be   = '1;
        st_data = wdata;
      end
      default: ;
    endcase
    case (memop)
      MEMOP_B:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_BU: ld_data = {24'h000000, byte_sel};
      MEMOP_H:  ld_data = {{16{half_sel[15]}}, half_sel};
      MEMOP_HU: ld_data = {16'h0000, half_sel};
      MEMOP_W:  ld_data = rword;
      default:  ld_data = '0;
    endcase
  end

endmodule

// File: rtl/sram_resp.sv
// sram_resp
//   Single-outstanding SRAM responder with fixed access latency.
//   Parameters: DEPTH_WORDS (32-bit words), BASE_ADDR (byte address of
//   word 0), LATENCY (cycles from accept to resp_valid, 1..15).
//   Ports:
//     clk, rst_n (async, active-low)
//     req_valid/req_ready, req_addr, req_wen, req_wdata, req_memop
//     resp_valid/resp_ready, resp_rdata, resp_err
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_memop,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [2:0]  memop_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             acc_err;
  logic             fire;
  logic             mem_we;
  logic [31:0]      rword;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      ld_data;

  // Range test split as addr >= BASE plus offset < span so a base near the
  // top of the address space cannot wrap the upper bound.
  assign offset   = addr_q - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign acc_err  = !in_range || !memop_legal(memop_q, wen_q) ||
                    memop_misaligned(memop_q, addr_q[1:0]);
  assign fire     = (state == WAIT) && (cnt == 4'd0);
  assign mem_we   = fire && wen_q && !acc_err;
  assign rword    = mem[idx];

  mem_lane_align u_align (
    .memop   (memop_q),
    .lane    (addr_q[1:0]),
    .wdata   (wdata_q),
    .rword   (rword),
    .st_be   (st_be),
    .st_data (st_data),
    .ld_data (ld_data)
  );

  // Storage is deliberately not reset; a reset cannot reach this edge
  // because the FSM is already back in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      memop_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wen_q     <= req_wen;
            memop_q   <= req_memop;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || wen_q) ? '0 : ld_data;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_resp.sv
module tb_sram_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [2:0]  req_memop;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  sram_resp #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .req_memop  (req_memop),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t ls_tbl [16] = '{
    '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3'd2, 32'h0000_0000, 1'b0},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0},
    '{32'h8000_0011, 1'b1, 32'hAAAA_AA55, 3'd0, 32'h0000_0000, 1'b0},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd2, 32'hDEAD_55EF, 1'b0},
    '{32'h8000_0013, 1'b0, 32'h0,         3'd0, 32'hFFFF_FFDE, 1'b0},
    '{32'h8000_0013, 1'b0, 32'h0,         3'd4, 32'h0000_00DE, 1'b0},
    '{32'h8000_0012, 1'b1, 32'h9999_1234, 3'd1, 32'h0000_0000, 1'b0},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd2, 32'h1234_55EF, 1'b0},
    '{32'h8000_0011, 1'b0, 32'h0,         3'd1, 32'h0000_0000, 1'b1},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd2, 32'h1234_55EF, 1'b0},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd0, 32'hFFFF_FFEF, 1'b0},
    '{32'h8000_0012, 1'b0, 32'h0,         3'd5, 32'h0000_1234, 1'b0},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd1, 32'h0000_55EF, 1'b0},
    '{32'h8000_0006, 1'b1, 32'h0000_F00D, 3'd1, 32'h0000_0000, 1'b0},
    '{32'h8000_0006, 1'b0, 32'h0,         3'd1, 32'hFFFF_F00D, 1'b0},
    '{32'h8000_0006, 1'b0, 32'h0,         3'd5, 32'h0000_F00D, 1'b0}
  };

  vec_t fault_tbl [16] = '{
    '{32'h8000_0000, 1'b1, 32'h1122_3344, 3'd2, 32'h0000_0000, 1'b0},
    '{32'h7FFF_FFFC, 1'b0, 32'h0,         3'd2, 32'h0000_0000, 1'b1},
    '{32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 3'd2, 32'h0000_0000, 1'b1},
    '{32'h8000_0000, 1'b0, 32'h0,         3'd2, 32'h1122_3344, 1'b0},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd3, 32'h0000_0000, 1'b1},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd6, 32'h0000_0000, 1'b1},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd7, 32'h0000_0000, 1'b1},
    '{32'h8000_0010, 1'b1, 32'h0,         3'd4, 32'h0000_0000, 1'b1},
    '{32'h8000_0012, 1'b1, 32'h0,         3'd5, 32'h0000_0000, 1'b1},
    '{32'h8000_0012, 1'b1, 32'h0,         3'd2, 32'h0000_0000, 1'b1},
    '{32'h8000_0011, 1'b1, 32'h0,         3'd1, 32'h0000_0000, 1'b1},
    '{32'h8000_0010, 1'b0, 32'h0,         3'd2, 32'h1234_55EF, 1'b0},
    '{32'h8000_0FFC, 1'b1, 32'hAABB_CCDD, 3'd2, 32'h0000_0000, 1'b0},
    '{32'h8000_0FFC, 1'b0, 32'h0,         3'd2, 32'hAABB_CCDD, 1'b0},
    '{32'h8000_0FFF, 1'b0, 32'h0,         3'd0, 32'hFFFF_FFAA, 1'b0},
    '{32'h8000_1000, 1'b0, 32'h0,         3'd2, 32'h0000_0000, 1'b1}
  };

  // Byte-addressed reference memory, keyed by offset from BASE.
  bit [7:0] mb [int unsigned];

  function automatic void model(input logic [31:0] addr, input logic wen,
                                input logic [31:0] wdata, input logic [2:0] op,
                                output logic [31:0] rd, output logic e);
    int unsigned size;
    bit          legal;
    longint      a;
    int unsigned off;
    logic [31:0] v;
    rd    = '0;
    size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
            (((op == 3'd4) || (op == 3'd5)) && !wen);
    a     = longint'(addr);
    e     = !legal || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH) ||
            ((addr % size) != 0);
    if (e) return;
    off = addr - BASE;
    if (wen) begin
      for (int k = 0; k < int'(size); k++) mb[off + k] = wdata[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < int'(size); k++)
        v = v | ({24'h0, (mb.exists(off + k) ? mb[off + k] : 8'h00)} << (8 * k));
      if (op < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endfunction

  // Presents one request, then scrambles the request inputs once it has
  // been accepted; returns the first sampled response and its latency.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [2:0] op, output logic [31:0] rd, output logic e,
                       output int lat, output bit ok);
    int n;
    rd  = '0;
    e   = 1'b0;
    lat = 0;
    ok  = 1'b1;
    @(negedge clk);
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_memop = op;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required=1", a, req_ready);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wen   = 1'($urandom);
    req_memop = 3'($urandom);
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk);
      #1;
      lat++;
      n++;
    end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout addr=%h resp_valid=%b required=1", a, resp_valid);
      ok = 1'b0;
      return;
    end
    rd = resp_rdata;
    e  = resp_err;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wen    = 1'b0;
    req_wdata  = '0;
    req_memop  = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++;
    if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    total++;
    if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_load_store();
    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          ok;
    for (int i = 0; i < $size(ls_tbl); i++) begin
      issue(ls_tbl[i].addr, ls_tbl[i].wen, ls_tbl[i].wdata, ls_tbl[i].op, rd, e, lat, ok);
      if (ok) begin
        total++;
        if (rd !== ls_tbl[i].exp_rd) begin
          bad++; $display("FAIL ls_rdata[%0d] got=%h want=%h", i, rd, ls_tbl[i].exp_rd);
        end
        total++;
        if (e !== ls_tbl[i].exp_err) begin
          bad++; $display("FAIL ls_err[%0d] got=%b want=%b", i, e, ls_tbl[i].exp_err);
        end
        total++;
        if (lat != LAT) begin bad++; $display("FAIL ls_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          ok;
    for (int i = 0; i < $size(fault_tbl); i++) begin
      issue(fault_tbl[i].addr, fault_tbl[i].wen, fault_tbl[i].wdata, fault_tbl[i].op, rd, e, lat, ok);
      if (ok) begin
        total++;
        if (rd !== fault_tbl[i].exp_rd) begin
          bad++; $display("FAIL fault_rdata[%0d] got=%h want=%h", i, rd, fault_tbl[i].exp_rd);
        end
        total++;
        if (e !== fault_tbl[i].exp_err) begin
          bad++; $display("FAIL fault_err[%0d] got=%b want=%b", i, e, fault_tbl[i].exp_err);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          ok;
    resp_ready = 1'b0;
    issue(32'h8000_0010, 1'b0, 32'h0, 3'd2, rd, e, lat, ok);
    // A second request held during the stall must be ignored.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    req_wen   = 1'b1;
    req_memop = 3'd2;
    req_wdata = 32'h0BAD_0BAD;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", c, resp_valid); end
      total++;
      if (resp_rdata !== 32'h1234_55EF) begin
        bad++; $display("FAIL bp_rdata[%0d] got=%h want=123455ef", c, resp_rdata);
      end
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b want=0", c, req_ready); end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", resp_valid); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", req_ready); end
    issue(32'h8000_0000, 1'b0, 32'h0, 3'd2, rd, e, lat, ok);
    if (ok) begin
      total++;
      if (rd !== 32'h1122_3344) begin bad++; $display("FAIL bp_ignored_req got=%h want=11223344", rd); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd;
    logic        e;
    int          lat;
    bit          ok;
    @(negedge clk);
    req_addr  = 32'h8000_0010;
    req_wen   = 1'b1;
    req_wdata = 32'hCAFE_F00D;
    req_memop = 3'd2;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", resp_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_resp[%0d] got=%b want=0", c, resp_valid); end
    end
    issue(32'h8000_0010, 1'b0, 32'h0, 3'd2, rd, e, lat, ok);
    if (ok) begin
      total++;
      if (rd !== 32'h1234_55EF) begin bad++; $display("FAIL midrst_old_data got=%h want=123455ef", rd); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, a, d;
    logic        e, exp_e, w;
    logic [2:0]  op;
    int          lat;
    bit          ok;
    int unsigned sel;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      a = BASE + 32'h100 + 32'(4 * i);
      model(a, 1'b1, d, 3'd2, exp_rd, exp_e);
      issue(a, 1'b1, d, 3'd2, rd, e, lat, ok);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else if (sel == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else               a = BASE + 32'h100 + 32'($urandom_range(0, 63));
      w  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      model(a, w, d, op, exp_rd, exp_e);
      issue(a, w, d, op, rd, e, lat, ok);
      if (ok) begin
        total++;
        if (rd !== exp_rd || e !== exp_e) begin
          bad++;
          $display("FAIL rand[%0d] a=%h w=%b op=%0d got rd=%h err=%b want rd=%h err=%b",
                   i, a, w, op, rd, e, exp_rd, exp_e);
        end
        total++;
        if (lat != LAT) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
      end
      @(posedge clk);
      #1;
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rand_idle[%0d] got ready=%b valid=%b want ready=1 valid=0", i, req_ready, resp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_faults();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
